// File: rtl/conv_seq_ctrl_pkg.sv
// Shared types and helpers for the convolution sequencer.
package conv_ctrl_pkg;

    // Sequencer states; encodings 10..15 are unreachable and recover to IDLE.
    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        LOAD,
        MAC,
        SUM,
        ACC,
        BIAS,
        STORE,
        UPDATE,
        DONE
    } state_t;

    // mux_sel value that selects the row-product sum (also the idle value).
    localparam int MUX_SUM = 0;

    // Index width for a counter of n values; never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_seq_ctrl_if.sv
// Control/strobe bundle between the sequencer and the datapath blocks.
interface conv_seq_ctrl_if
    import conv_ctrl_pkg::*;
#(
    parameter int KH    = 3,
    parameter int C_IN  = 1,
    parameter int OUT_W = 26,
    parameter int OUT_H = 26,
    parameter int SEL_W = $clog2(KH + 1)
);
    localparam int CW = clog2_min1(C_IN);
    localparam int XW = clog2_min1(OUT_W);
    localparam int YW = clog2_min1(OUT_H);

    logic          start;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic          addr;
    logic          load;
    logic [SEL_W-1:0] mux_sel;
    logic          flush_acc;
    logic          acc_enable;
    logic          bias_enable;
    logic          store;
    logic [XW-1:0] col_idx;
    logic [YW-1:0] row_idx;
    logic [CW-1:0] chan_idx;

    // Sequencer side.
    modport master (
        input  start, out_ready,
        output busy, done, addr, load, mux_sel, flush_acc, acc_enable,
               bias_enable, store, col_idx, row_idx, chan_idx
    );

    // Top-level control / datapath side.
    modport slave (
        output start, out_ready,
        input  busy, done, addr, load, mux_sel, flush_acc, acc_enable,
               bias_enable, store, col_idx, row_idx, chan_idx
    );

endinterface

// File: rtl/conv_seq_ctrl_pos_counter.sv
// Nested channel / column / row position counter for the sequencer.
module conv_pos_counter
    import conv_ctrl_pkg::*;
#(
    parameter int C_IN  = 1,
    parameter int OUT_W = 26,
    parameter int OUT_H = 26,
    localparam int CW = clog2_min1(C_IN),
    localparam int XW = clog2_min1(OUT_W),
    localparam int YW = clog2_min1(OUT_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          chan_inc,
    input  logic          pix_inc,
    output logic          last_chan,
    output logic          last_pix,
    output logic [CW-1:0] chan_idx,
    output logic [XW-1:0] col_idx,
    output logic [YW-1:0] row_idx
);
    localparam logic [CW-1:0] CHAN_LAST = CW'(C_IN - 1);
    localparam logic [XW-1:0] COL_LAST  = XW'(OUT_W - 1);
    localparam logic [YW-1:0] ROW_LAST  = YW'(OUT_H - 1);

    assign last_chan = (chan_idx == CHAN_LAST);
    assign last_pix  = (col_idx == COL_LAST) && (row_idx == ROW_LAST);

    // clr restarts the sweep; a pixel step clears the channel and moves raster-order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chan_idx <= '0;
            col_idx  <= '0;
            row_idx  <= '0;
        end else if (clr) begin
            chan_idx <= '0;
            col_idx  <= '0;
            row_idx  <= '0;
        end else if (pix_inc) begin
            chan_idx <= '0;
            if (col_idx == COL_LAST) begin
                col_idx <= '0;
                row_idx <= (row_idx == ROW_LAST) ? '0 : row_idx + 1'b1;
            end else begin
                col_idx <= col_idx + 1'b1;
            end
        end else if (chan_inc) begin
            chan_idx <= chan_idx + 1'b1;
        end
    end

endmodule

// File: rtl/conv_seq_ctrl.sv
// Convolution sequencer: walks every output pixel, KH MAC beats per input
// channel, optional bias, then a back-pressured store.
module conv_seq_ctrl
    import conv_ctrl_pkg::*;
#(
    parameter int KH      = 3,
    parameter int C_IN    = 1,
    parameter int OUT_W   = 26,
    parameter int OUT_H   = 26,
    parameter int BIAS_EN = 1,
    parameter int SEL_W   = $clog2(KH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    conv_seq_ctrl_if.master bus
);
    localparam logic [SEL_W-1:0] BEAT_LAST = SEL_W'(KH);

    state_t state, nxt;
    logic   last_chan, last_pix;
    logic   clr, chan_inc, pix_inc;

    logic             busy_r, done_r, addr_r, load_r, flush_r;
    logic             acc_r, bias_r, store_r;
    logic [SEL_W-1:0] mux_r;

    // Counter steps follow the current state so indices stay registered.
    assign clr      = (state == IDLE) && bus.start;
    assign chan_inc = (state == ACC) && !last_chan;
    assign pix_inc  = (state == UPDATE);

    conv_pos_counter #(
        .C_IN  (C_IN),
        .OUT_W (OUT_W),
        .OUT_H (OUT_H)
    ) u_pos (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .chan_inc  (chan_inc),
        .pix_inc   (pix_inc),
        .last_chan (last_chan),
        .last_pix  (last_pix),
        .chan_idx  (bus.chan_idx),
        .col_idx   (bus.col_idx),
        .row_idx   (bus.row_idx)
    );

    // Next-state decision; in MAC the mux_sel register doubles as the beat counter.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (bus.start) nxt = ADDR;
            ADDR:    nxt = LOAD;
            LOAD:    nxt = MAC;
            MAC:     if (mux_r == BEAT_LAST) nxt = SUM;
            SUM:     nxt = ACC;
            ACC:     nxt = !last_chan ? ADDR : ((BIAS_EN != 0) ? BIAS : STORE);
            BIAS:    nxt = STORE;
            STORE:   if (bus.out_ready) nxt = UPDATE;
            UPDATE:  nxt = last_pix ? DONE : ADDR;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // State register with outputs decoded from the next state, so every strobe is a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            addr_r  <= 1'b0;
            load_r  <= 1'b0;
            flush_r <= 1'b0;
            acc_r   <= 1'b0;
            bias_r  <= 1'b0;
            store_r <= 1'b0;
            mux_r   <= SEL_W'(MUX_SUM);
        end else begin
            state   <= nxt;
            busy_r  <= (nxt != IDLE);
            done_r  <= (nxt == DONE);
            addr_r  <= (nxt == ADDR);
            // ADDR entered from ACC is a later channel of the same pixel: keep the sum.
            flush_r <= (nxt == ADDR) && (state != ACC);
            load_r  <= (nxt == LOAD);
            acc_r   <= (nxt == ACC);
            bias_r  <= (nxt == BIAS);
            store_r <= (nxt == STORE);
            if (nxt == MAC)
                mux_r <= (state == MAC) ? mux_r + 1'b1 : SEL_W'(1);
            else
                mux_r <= SEL_W'(MUX_SUM);
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.addr        = addr_r;
    assign bus.load        = load_r;
    assign bus.flush_acc   = flush_r;
    assign bus.acc_enable  = acc_r;
    assign bus.bias_enable = bias_r;
    assign bus.store       = store_r;
    assign bus.mux_sel     = mux_r;

endmodule
